// File: rtl/tick_monitor_pkg.sv
// Shared definitions for the tick monitor and the upstream wrap-counter block:
// FSM state encoding and default timing constants.
package tick_monitor_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StAcq    = 2'd1,
    StLocked = 2'd2
  } tick_state_e;

  localparam int unsigned DefaultPeriod    = 53;
  localparam int unsigned DefaultCw        = 6;
  localparam int unsigned DefaultLockCount = 3;
  localparam int unsigned ErrCountWidth    = 8;

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tick_monitor.sv
// Watches a periodic one-cycle strobe, locks after a run of correctly spaced ticks,
// and flags early or missing ticks once locked.
module tick_monitor
  import tick_monitor_pkg::*;
#(
  parameter int unsigned PERIOD     = DefaultPeriod,
  parameter int unsigned CW         = DefaultCw,
  parameter int unsigned LOCK_COUNT = DefaultLockCount
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_in,
  output logic                     locked,
  output logic                     err,
  output logic [ErrCountWidth-1:0] err_count,
  output logic [CW-1:0]            last_period,
  output logic [1:0]               state
);

  localparam logic [CW-1:0] GapLast    = CW'(PERIOD - 1);
  localparam logic [3:0]    LockTarget = 4'(LOCK_COUNT);

  tick_state_e   state_q, state_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [CW-1:0] last_period_q, last_period_d;
  logic [3:0]    good_cnt_q, good_cnt_d;
  logic          err_q, err_d;
  logic          at_last;
  logic [CW-1:0] gap_inc;

  // A tick seen while the gap sits at PERIOD-1 is on time; no tick then means it was missed.
  assign at_last = (gap_q == GapLast);
  assign gap_inc = gap_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    gap_d         = tick_in ? '0 : gap_inc;
    last_period_d = last_period_q;
    good_cnt_d    = good_cnt_q;
    err_d         = 1'b0;

    case (state_q)
      StHunt: begin
        gap_d = '0;
        if (tick_in) begin
          state_d    = StAcq;
          good_cnt_d = '0;
        end
      end

      StAcq: begin
        if (tick_in) begin
          last_period_d = gap_inc;
          if (at_last) begin
            if ((good_cnt_q + 4'd1) == LockTarget) begin
              state_d    = StLocked;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            good_cnt_d = '0;
          end
        end else if (at_last) begin
          state_d    = StHunt;
          good_cnt_d = '0;
          gap_d      = '0;
        end
      end

      StLocked: begin
        if (tick_in) begin
          last_period_d = gap_inc;
          if (!at_last) begin
            err_d      = 1'b1;
            state_d    = StAcq;
            good_cnt_d = '0;
          end
        end else if (at_last) begin
          err_d      = 1'b1;
          state_d    = StHunt;
          good_cnt_d = '0;
          gap_d      = '0;
        end
      end

      default: begin
        state_d    = StHunt;
        gap_d      = '0;
        good_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StHunt;
      gap_q         <= '0;
      last_period_q <= '0;
      good_cnt_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      last_period_q <= last_period_d;
      good_cnt_q    <= good_cnt_d;
      err_q         <= err_d;
    end
  end

  // Counts on the same edge that registers err.
  sat_counter #(
    .Width(ErrCountWidth)
  ) u_err_count (
    .clk  (clk),
    .reset(reset),
    .inc  (err_d),
    .count(err_count)
  );

  assign locked      = (state_q == StLocked);
  assign err         = err_q;
  assign last_period = last_period_q;
  assign state       = state_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Self-checking bench: default-parameter instance driven from a vector table and
// hand sequences, plus a PERIOD=4 / LOCK_COUNT=1 instance for short-period and saturation.
module tb_tick_monitor;
  import tick_monitor_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       locked, err;
  logic [7:0] err_count;
  logic [5:0] last_period;
  logic [1:0] state;

  logic       s_tick = 1'b0;
  logic       s_locked, s_err;
  logic [7:0] s_err_count;
  logic [2:0] s_last_period;
  logic [1:0] s_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .last_period(last_period),
    .state      (state)
  );

  tick_monitor #(
    .PERIOD    (4),
    .CW        (3),
    .LOCK_COUNT(1)
  ) dut_s (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (s_tick),
    .locked     (s_locked),
    .err        (s_err),
    .err_count  (s_err_count),
    .last_period(s_last_period),
    .state      (s_state)
  );

  typedef struct packed {
    int         gap;  // clocks from previous tick to this one
    logic [1:0] st;
    logic       lk;
    logic       er;
    int         lp;
    int         cnt;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic t);
    tick_in = t;
    @(posedge clk);
    #1;
    tick_in = 1'b0;
  endtask

  task automatic scyc(input logic t);
    s_tick = t;
    @(posedge clk);
    #1;
    s_tick = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    for (int i = 1; i < v.gap; i++) begin
      cyc(1'b0);
      chk({tag, "_idle_err"}, int'(err), 0);
    end
    exp_q.push_back(v);
    cyc(1'b1);
    e = exp_q.pop_front();
    chk({tag, "_state"}, int'(state), int'(e.st));
    chk({tag, "_locked"}, int'(locked), int'(e.lk));
    chk({tag, "_err"}, int'(err), int'(e.er));
    chk({tag, "_last_period"}, int'(last_period), e.lp);
    chk({tag, "_err_count"}, int'(err_count), e.cnt);
  endtask

  // Three on-time ticks from ACQ with good_cnt=0 end in LOCKED.
  task automatic relock(input int cnt, input string tag);
    run_vec('{53, StAcq, 1'b0, 1'b0, 53, cnt}, {tag, "_g1"});
    run_vec('{53, StAcq, 1'b0, 1'b0, 53, cnt}, {tag, "_g2"});
    run_vec('{53, StLocked, 1'b1, 1'b0, 53, cnt}, {tag, "_g3"});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, int'(state), int'(StHunt));
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
    chk({tag, "_last_period"}, int'(last_period), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_cnt;

    vecs[0]  = '{5,  StAcq,    1'b0, 1'b0, 0,  0};
    vecs[1]  = '{53, StAcq,    1'b0, 1'b0, 53, 0};
    vecs[2]  = '{53, StAcq,    1'b0, 1'b0, 53, 0};
    vecs[3]  = '{53, StLocked, 1'b1, 1'b0, 53, 0};
    vecs[4]  = '{53, StLocked, 1'b1, 1'b0, 53, 0};
    vecs[5]  = '{20, StAcq,    1'b0, 1'b1, 20, 1};
    vecs[6]  = '{53, StAcq,    1'b0, 1'b0, 53, 1};
    vecs[7]  = '{53, StAcq,    1'b0, 1'b0, 53, 1};
    vecs[8]  = '{53, StLocked, 1'b1, 1'b0, 53, 1};
    vecs[9]  = '{1,  StAcq,    1'b0, 1'b1, 1,  2};
    vecs[10] = '{52, StAcq,    1'b0, 1'b0, 52, 2};
    vecs[11] = '{53, StAcq,    1'b0, 1'b0, 53, 2};
    vecs[12] = '{53, StAcq,    1'b0, 1'b0, 53, 2};
    vecs[13] = '{53, StLocked, 1'b1, 1'b0, 53, 2};

    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    chk("por_s_state", int'(s_state), int'(StHunt));
    reset = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("idle_hunt_state", int'(state), int'(StHunt));

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Missing tick while locked: err exactly on the 53rd clock after the last tick.
    for (int k = 1; k < 53; k++) begin
      cyc(1'b0);
      chk("miss_pre_err", int'(err), 0);
    end
    cyc(1'b0);
    chk("miss_err", int'(err), 1);
    chk("miss_state", int'(state), int'(StHunt));
    chk("miss_locked", int'(locked), 0);
    chk("miss_err_count", int'(err_count), 3);
    chk("miss_last_period", int'(last_period), 53);
    cyc(1'b0);
    chk("miss_err_pulse", int'(err), 0);
    run_vec('{4, StAcq, 1'b0, 1'b0, 53, 3}, "hunt_tick");

    // Missing tick in ACQ: back to HUNT silently.
    for (int k = 1; k <= 53; k++) begin
      cyc(1'b0);
      chk("acq_miss_err", int'(err), 0);
    end
    chk("acq_miss_state", int'(state), int'(StHunt));
    chk("acq_miss_err_count", int'(err_count), 3);

    // Build err_count up to 5 and finish in LOCKED.
    run_vec('{2, StAcq, 1'b0, 1'b0, 53, 3}, "re_hunt");
    relock(3, "lockA");
    run_vec('{10, StAcq, 1'b0, 1'b1, 10, 4}, "early10");
    relock(4, "lockB");
    run_vec('{1, StAcq, 1'b0, 1'b1, 1, 5}, "b2b");
    relock(5, "lockC");

    // Asynchronous reset in LOCKED, checked before the next clock edge.
    #2;
    reset = 1'b1;
    #1;
    check_reset("async");
    repeat (3) @(posedge clk);
    #1;
    check_reset("held");
    reset = 1'b0;
    cyc(1'b0);
    check_reset("post");
    run_vec('{3, StAcq, 1'b0, 1'b0, 0, 0}, "after_rst");

    // Short-period instance: lock after the 2nd tick, back-to-back ticks error.
    scyc(1'b1);
    chk("s_first_state", int'(s_state), int'(StAcq));
    repeat (3) scyc(1'b0);
    scyc(1'b1);
    chk("s_lock_state", int'(s_state), int'(StLocked));
    chk("s_lock_locked", int'(s_locked), 1);
    chk("s_lock_last_period", int'(s_last_period), 4);
    scyc(1'b1);
    chk("s_b2b_err", int'(s_err), 1);
    chk("s_b2b_last_period", int'(s_last_period), 1);
    chk("s_b2b_state", int'(s_state), int'(StAcq));
    chk("s_b2b_err_count", int'(s_err_count), 1);

    // 299 more violations; the counter must stop at 255.
    exp_cnt = 1;
    for (int n = 2; n <= 300; n++) begin
      repeat (3) scyc(1'b0);
      scyc(1'b1);
      chk("s_sat_relock", int'(s_locked), 1);
      scyc(1'b1);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      chk("s_sat_err", int'(s_err), 1);
      chk("s_sat_err_count", int'(s_err_count), exp_cnt);
    end
    scyc(1'b0);
    chk("s_sat_err_pulse", int'(s_err), 0);
    chk("s_sat_final", int'(s_err_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 Parameter PERIOD, default 53: expected clocks between consecutive tick_in pulses (generator counts 0..52 and then wraps).
REQ-002 Parameter CW, default 6: gap/period counter width; PERIOD SHALL satisfy 2 <= PERIOD <= 2^CW - 1.
REQ-003 Parameter LOCK_COUNT, default 3: consecutive good periods required to lock; range 1..15.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 tick_in  in  1  one-cycle strobe from the upstream wrap counter.
REQ-007 locked  out  1  high while state is LOCKED.
REQ-008 err  out  1  one-cycle pulse on a period violation while LOCKED.
REQ-009 err_count  out  8  number of err pulses, saturating at 255.
REQ-010 last_period  out  CW  clocks between the two most recent ticks.
REQ-011 state  out  2  current FSM state: HUNT=0, ACQ=1, LOCKED=2.

Function
REQ-012 Internal gap counter: cleared to 0 in any cycle with tick_in=1; otherwise increments by 1 in ACQ or LOCKED; held at 0 in HUNT.
REQ-013 A tick is good when gap == PERIOD-1 in the cycle tick_in=1; any other value marks the tick as bad (early).
REQ-014 The tick is missing when gap == PERIOD-1 and tick_in=0, in ACQ or LOCKED.
REQ-015 HUNT: when tick_in=1, go to ACQ with good_cnt=0; otherwise stay in HUNT; err never asserted.
REQ-016 ACQ, good tick: increment good_cnt; when the count reaches LOCK_COUNT, go to LOCKED and clear good_cnt.
REQ-017 ACQ, bad tick: stay in ACQ, good_cnt=0, restart measurement from this tick, no err.
REQ-018 ACQ, missing tick: go to HUNT, good_cnt=0, no err.
REQ-019 LOCKED, good tick: stay in LOCKED, no err.
REQ-020 LOCKED, bad tick: err=1 for one cycle, go to ACQ with good_cnt=0.
REQ-021 LOCKED, missing tick: err=1 for one cycle, go to HUNT.
REQ-022 On every tick in ACQ or LOCKED, last_period SHALL load gap+1 on the same edge; otherwise it holds.
REQ-023 err_count increments on the same edge err is registered and holds at 255 once reached.
REQ-024 All outputs are registered, with no combinational path from tick_in; err and state change on the edge after the tick edge.
REQ-025 Consecutive-cycle ticks in LOCKED (gap=0) are bad; each one produces err, last_period=1, and a return to ACQ.

Reset
REQ-026 While reset=1: state=HUNT, locked=0, err=0, err_count=0, last_period=0, gap=0, good_cnt=0.
REQ-027 Reset asserted mid-period or in LOCKED discards all history; the first tick after release is treated as a HUNT tick.
REQ-028 tick_in coincident with reset deassertion is ignored only if it arrives before the first post-release rising edge.

Structure
REQ-029 A shared package SHALL hold the state encoding (HUNT/ACQ/LOCKED) and the default constants PERIOD=53, CW=6, LOCK_COUNT=3, shared with the wrap-counter block.
REQ-030 One sub-module, sat_counter (8-bit, increment-enable, saturating, async reset), SHALL implement err_count.
REQ-031 The FSM, gap counter and good_cnt SHALL live in tick_monitor; expected size 120-250 lines.

Verification
REQ-032 Drive the wrap counter's strobe (tick every 53 clks) from reset release -> state HUNT->ACQ on the 1st tick, locked=1 one edge after the 4th tick, last_period=53, err never asserted.
REQ-033 After lock, inject a tick 20 clks after the previous one -> err pulses once, err_count=1, last_period=20, state=ACQ, relock after 3 further good periods.
REQ-034 After lock, suppress one tick -> err pulses exactly 53 clks after the last tick, err_count increments, state=HUNT, locked=0; the next tick enters ACQ.
REQ-035 Assert reset for 3 clks while LOCKED with err_count=5 -> all outputs return to reset values immediately (asynchronously), no err pulse.
REQ-036 Force 300 violations (alternating lock and early tick) -> err_count stops at 255 and does not wrap.
REQ-037 Run with PERIOD=4, LOCK_COUNT=1 -> lock one edge after the 2nd tick; back-to-back ticks give last_period=1 and err.
